// File: rtl/hex_seq_checker_pkg.sv
// hex_seq_checker_pkg: segment codes, roll-number sequence, FSM states.
// Shared by the decoder, the interface and the checker top.
package hex_seq_checker_pkg;

  localparam int POS_W = 3;

  localparam logic [6:0] N0 = 7'b1000000;
  localparam logic [6:0] N1 = 7'b1111001;
  localparam logic [6:0] N2 = 7'b0100100;
  localparam logic [6:0] N3 = 7'b0110000;
  localparam logic [6:0] N4 = 7'b0011001;
  localparam logic [6:0] N5 = 7'b0010010;
  localparam logic [6:0] N6 = 7'b0000010;
  localparam logic [6:0] N7 = 7'b1111000;
  localparam logic [6:0] N8 = 7'b0000000;
  localparam logic [6:0] N9 = 7'b0010000;

  localparam logic [POS_W-1:0] NOT_IN_SEQ = 3'd7;

  typedef enum logic {
    HUNT  = 1'b0,
    TRACK = 1'b1
  } state_t;

  // Roll-number table 5-7-9-8-3, indexed by pos.
  function automatic logic [3:0] seq_digit(
    input logic [POS_W-1:0] idx
  );
    logic [3:0] d;
    case (idx)
      3'd0:    d = 4'd5;
      3'd1:    d = 4'd7;
      3'd2:    d = 4'd9;
      3'd3:    d = 4'd8;
      3'd4:    d = 4'd3;
      default: d = 4'hF;
    endcase
    return d;
  endfunction

  // Inverse of the table; NOT_IN_SEQ for other digits.
  function automatic logic [POS_W-1:0] seq_index(
    input logic [3:0] d
  );
    logic [POS_W-1:0] i;
    case (d)
      4'd5:    i = 3'd0;
      4'd7:    i = 3'd1;
      4'd9:    i = 3'd2;
      4'd8:    i = 3'd3;
      4'd3:    i = 3'd4;
      default: i = NOT_IN_SEQ;
    endcase
    return i;
  endfunction

  // Next index around the 5-entry ring.
  function automatic logic [POS_W-1:0] seq_step(
    input logic [POS_W-1:0] p,
    input logic             fwd
  );
    logic [POS_W-1:0] n;
    if (fwd)
      n = (p == 3'd4) ? 3'd0 : p + 3'd1;
    else
      n = (p == 3'd0) ? 3'd4 : p - 3'd1;
    return n;
  endfunction

endpackage

// File: rtl/hex_seq_checker_if.sv
// hex_seq_checker_if: monitor bus (seg_in/sample/dir/clr_err in,
// digit/digit_valid/pos/in_sync/err/err_count out).
interface hex_seq_checker_if #(
  parameter int ERR_W = 8
) ();
  import hex_seq_checker_pkg::*;

  logic [6:0]       seg_in;
  logic             sample;
  logic             dir;
  logic             clr_err;
  logic [3:0]       digit;
  logic             digit_valid;
  logic [POS_W-1:0] pos;
  logic             in_sync;
  logic             err;
  logic [ERR_W-1:0] err_count;

  modport master (
    output seg_in, sample, dir, clr_err,
    input  digit, digit_valid, pos,
    input  in_sync, err, err_count
  );

  modport slave (
    input  seg_in, sample, dir, clr_err,
    output digit, digit_valid, pos,
    output in_sync, err, err_count
  );

endinterface

// File: rtl/hex_seq_checker_seg7_decode.sv
// seg7_decode: active-low 7-seg pattern (g..a) to digit 0..9.
// Ports: seg in; digit out (4'hF if unknown); valid out.
module hex_seq_checker_seg7_decode
  import hex_seq_checker_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] digit,
  output logic       valid
);

  always_comb begin
    digit = 4'hF;
    valid = 1'b0;
    unique case (1'b1)
      (seg == N0): begin digit = 4'd0; valid = 1'b1; end
      (seg == N1): begin digit = 4'd1; valid = 1'b1; end
      (seg == N2): begin digit = 4'd2; valid = 1'b1; end
      (seg == N3): begin digit = 4'd3; valid = 1'b1; end
      (seg == N4): begin digit = 4'd4; valid = 1'b1; end
      (seg == N5): begin digit = 4'd5; valid = 1'b1; end
      (seg == N6): begin digit = 4'd6; valid = 1'b1; end
      (seg == N7): begin digit = 4'd7; valid = 1'b1; end
      (seg == N8): begin digit = 4'd8; valid = 1'b1; end
      (seg == N9): begin digit = 4'd9; valid = 1'b1; end
      default: ;
    endcase
  end

endmodule

// File: rtl/hex_seq_checker.sv
// hex_seq_checker: tracks the 5-7-9-8-3 roll sequence on a HEX display.
// Ports: clk, reset (async high), bus (slave). Macro: HEX_CHK_REPEAT_EN.
module hex_seq_checker
  import hex_seq_checker_pkg::*;
#(
  parameter int MISS_LIMIT = 2,
  parameter int ERR_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  hex_seq_checker_if.slave bus
);

  localparam logic [2:0] MISS_LAST = 3'(MISS_LIMIT - 1);

  logic [3:0]       dec_digit;
  logic             dec_valid;
  logic [POS_W-1:0] exp_pos;
  logic [POS_W-1:0] hit_pos;
  logic             match;
  logic             repeat_hit;

  state_t           state_q;
  logic [POS_W-1:0] pos_q;
  logic [2:0]       miss_q;
  logic [3:0]       digit_q;
  logic             valid_q;
  logic             err_q;
  logic [ERR_W-1:0] cnt_q;

  hex_seq_checker_seg7_decode u_seg7_decode (
    .seg   (bus.seg_in),
    .digit (dec_digit),
    .valid (dec_valid)
  );

  assign exp_pos = seq_step(pos_q, bus.dir);
  assign hit_pos = seq_index(dec_digit);
  assign match   = dec_valid &&
                   (dec_digit == seq_digit(exp_pos));

  // A re-strobe of the digit already shown is ignored.
`ifdef HEX_CHK_REPEAT_EN
  assign repeat_hit = dec_valid &&
                      (dec_digit == seq_digit(pos_q));
`else
  assign repeat_hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= HUNT;
      pos_q   <= '0;
      miss_q  <= '0;
      digit_q <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      err_q <= 1'b0;
      if (bus.sample) begin
        digit_q <= dec_digit;
        valid_q <= dec_valid;
        case (state_q)
          HUNT: begin
            if (dec_valid && hit_pos != NOT_IN_SEQ) begin
              state_q <= TRACK;
              pos_q   <= hit_pos;
              miss_q  <= '0;
            end
          end
          TRACK: begin
            if (match) begin
              pos_q  <= exp_pos;
              miss_q <= '0;
            end else if (!repeat_hit) begin
              err_q <= 1'b1;
              if (cnt_q != '1)
                cnt_q <= cnt_q + 1'b1;
              if (miss_q == MISS_LAST) begin
                state_q <= HUNT;
                miss_q  <= '0;
              end else begin
                miss_q <= miss_q + 3'd1;
              end
            end
          end
          default: state_q <= HUNT;
        endcase
      end
      // Last assignment: clear beats a same-edge increment.
      if (bus.clr_err)
        cnt_q <= '0;
    end
  end

  assign bus.digit       = digit_q;
  assign bus.digit_valid = valid_q;
  assign bus.pos         = pos_q;
  assign bus.in_sync     = (state_q == TRACK);
  assign bus.err         = err_q;
  assign bus.err_count   = cnt_q;

endmodule

// File: tb/tb_hex_seq_checker.sv
// tb_hex_seq_checker: directed stimulus, reference model, per-cycle compare.
// Two DUTs (ERR_W=8 and ERR_W=2) share the same input stream.
module tb_hex_seq_checker;

  localparam int MISS = 2;

  localparam logic [6:0] P1 = 7'b1111001;
  localparam logic [6:0] P3 = 7'b0110000;
  localparam logic [6:0] P5 = 7'b0010010;
  localparam logic [6:0] P7 = 7'b1111000;
  localparam logic [6:0] P8 = 7'b0000000;
  localparam logic [6:0] P9 = 7'b0010000;
  localparam logic [6:0] PB = 7'b1111111;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] seg = PB;
  logic       smp = 1'b0;
  logic       dirv = 1'b1;
  logic       clr = 1'b0;

  hex_seq_checker_if #(.ERR_W(8)) b8 ();
  hex_seq_checker_if #(.ERR_W(2)) b2 ();

  assign b8.seg_in  = seg;
  assign b8.sample  = smp;
  assign b8.dir     = dirv;
  assign b8.clr_err = clr;
  assign b2.seg_in  = seg;
  assign b2.sample  = smp;
  assign b2.dir     = dirv;
  assign b2.clr_err = clr;

  hex_seq_checker #(.MISS_LIMIT(MISS), .ERR_W(8)) dut8 (
    .clk   (clk),
    .reset (rst),
    .bus   (b8.slave)
  );

  hex_seq_checker #(.MISS_LIMIT(MISS), .ERR_W(2)) dut2 (
    .clk   (clk),
    .reset (rst),
    .bus   (b2.slave)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  logic [6:0] pats [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000
  };
  int seqd [5] = '{5, 7, 9, 8, 3};

  function automatic int decode(input logic [6:0] s);
    for (int i = 0; i < 10; i++)
      if (s == pats[i]) return i;
    return 15;
  endfunction

  function automatic int seq_idx(input int d);
    for (int i = 0; i < 5; i++)
      if (seqd[i] == d) return i;
    return -1;
  endfunction

  // Reference model state
  int m_track = 0;
  int m_pos   = 0;
  int m_miss  = 0;
  int m_digit = 0;
  int m_valid = 0;
  int m_err   = 0;
  int m_cnt8  = 0;
  int m_cnt2  = 0;

  always @(posedge clk or posedge rst) begin
    int d, e, rep;
    if (rst) begin
      m_track = 0; m_pos = 0; m_miss = 0;
      m_digit = 0; m_valid = 0; m_err = 0;
      m_cnt8 = 0; m_cnt2 = 0;
    end else begin
      m_err = 0;
      if (smp) begin
        d = decode(seg);
        m_digit = d;
        m_valid = (d != 15);
        if (m_track == 0) begin
          if (m_valid != 0 && seq_idx(d) >= 0) begin
            m_track = 1;
            m_pos = seq_idx(d);
            m_miss = 0;
          end
        end else begin
          e = dirv ? (m_pos + 1) % 5 : (m_pos + 4) % 5;
`ifdef HEX_CHK_REPEAT_EN
          rep = (m_valid != 0 && d == seqd[m_pos]);
`else
          rep = 0;
`endif
          if (m_valid != 0 && d == seqd[e]) begin
            m_pos = e;
            m_miss = 0;
          end else if (rep == 0) begin
            m_err = 1;
            m_cnt8 = (m_cnt8 < 255) ? m_cnt8 + 1 : 255;
            m_cnt2 = (m_cnt2 < 3) ? m_cnt2 + 1 : 3;
            m_miss = m_miss + 1;
            if (m_miss >= MISS) begin
              m_track = 0;
              m_miss = 0;
            end
          end
        end
      end
      if (clr) begin
        m_cnt8 = 0;
        m_cnt2 = 0;
      end
    end
  end

  task automatic chk(input string nm, input int act,
                     input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d",
               nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    chk("digit8", int'(b8.digit), m_digit);
    chk("valid8", int'(b8.digit_valid), m_valid);
    chk("pos8", int'(b8.pos), m_pos);
    chk("sync8", int'(b8.in_sync), m_track);
    chk("err8", int'(b8.err), m_err);
    chk("cnt8", int'(b8.err_count), m_cnt8);
    chk("digit2", int'(b2.digit), m_digit);
    chk("pos2", int'(b2.pos), m_pos);
    chk("sync2", int'(b2.in_sync), m_track);
    chk("err2", int'(b2.err), m_err);
    chk("cnt2", int'(b2.err_count), m_cnt2);
  end

  task automatic step(input logic [6:0] s, input logic sm,
                      input logic d, input logic c);
    seg  = s;
    smp  = sm;
    dirv = d;
    clr  = c;
    @(negedge clk);
    smp = 1'b0;
    clr = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_digit", int'(b8.digit), 0);
    chk("rst_valid", int'(b8.digit_valid), 0);
    chk("rst_sync", int'(b8.in_sync), 0);
    chk("rst_cnt", int'(b8.err_count), 0);

    // 1: lock on 5
    step(P5, 1, 1, 0);
    chk("t1_digit", int'(b8.digit), 5);
    chk("t1_valid", int'(b8.digit_valid), 1);
    chk("t1_pos", int'(b8.pos), 0);
    chk("t1_sync", int'(b8.in_sync), 1);
    chk("t1_err", int'(b8.err), 0);

    // 2: full forward lap
    step(P7, 1, 1, 0); chk("t2_pos1", int'(b8.pos), 1);
    step(P9, 1, 1, 0); chk("t2_pos2", int'(b8.pos), 2);
    step(P8, 1, 1, 0); chk("t2_pos3", int'(b8.pos), 3);
    step(P3, 1, 1, 0); chk("t2_pos4", int'(b8.pos), 4);
    step(P5, 1, 1, 0); chk("t2_pos0", int'(b8.pos), 0);
    chk("t2_cnt", int'(b8.err_count), 0);

    // 3: backward wrap, then mismatch
    step(P3, 1, 0, 0); chk("t3_pos4", int'(b8.pos), 4);
    step(P9, 1, 0, 0);
    chk("t3_err", int'(b8.err), 1);
    chk("t3_cnt", int'(b8.err_count), 1);
    chk("t3_pos", int'(b8.pos), 4);
    chk("t3_sync", int'(b8.in_sync), 1);
    step(PB, 0, 0, 0);
    chk("t3_err_low", int'(b8.err), 0);

    // 4: two blanks drop sync, then relock on 8
    step(P8, 1, 0, 0); chk("t4_pos3", int'(b8.pos), 3);
    step(PB, 0, 0, 1);
    step(PB, 1, 0, 0);
    chk("t4_digitF", int'(b8.digit), 15);
    chk("t4_valid", int'(b8.digit_valid), 0);
    chk("t4_sync1", int'(b8.in_sync), 1);
    step(PB, 1, 0, 0);
    chk("t4_cnt", int'(b8.err_count), 2);
    chk("t4_sync0", int'(b8.in_sync), 0);
    chk("t4_poshold", int'(b8.pos), 3);
    step(P8, 1, 1, 0);
    chk("t4_relock", int'(b8.in_sync), 1);
    chk("t4_pos", int'(b8.pos), 3);

    // 5: saturation of the 2-bit counter, clear wins
    step(PB, 0, 1, 1);
    step(P1, 1, 1, 0); chk("t5_c1", int'(b2.err_count), 1);
    step(P1, 1, 1, 0); chk("t5_c2", int'(b2.err_count), 2);
    step(P8, 1, 1, 0);
    step(P1, 1, 1, 0); chk("t5_c3", int'(b2.err_count), 3);
    step(P1, 1, 1, 0); chk("t5_sat", int'(b2.err_count), 3);
    step(P8, 1, 1, 0);
    step(P1, 1, 1, 1); chk("t5_clr", int'(b2.err_count), 0);
    chk("t5_err", int'(b2.err), 1);

    // 6: repeated digit at pos 2
    step(P9, 1, 0, 0); chk("t6_pos2", int'(b8.pos), 2);
    step(P9, 1, 1, 0);
    chk("t6_pos", int'(b8.pos), 2);
`ifdef HEX_CHK_REPEAT_EN
    chk("t6_err", int'(b8.err), 0);
    chk("t6_cnt", int'(b8.err_count), 0);
`else
    chk("t6_err", int'(b8.err), 1);
    chk("t6_cnt", int'(b8.err_count), 1);
`endif

    // async reset mid-TRACK
    #2 rst = 1'b1;
    #1;
    chk("ar_sync", int'(b8.in_sync), 0);
    chk("ar_pos", int'(b8.pos), 0);
    chk("ar_digit", int'(b8.digit), 0);
    chk("ar_err", int'(b8.err), 0);
    chk("ar_cnt2", int'(b2.err_count), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // HUNT ignores out-of-sequence digits
    step(P1, 1, 1, 0);
    chk("h_sync", int'(b8.in_sync), 0);
    chk("h_err", int'(b8.err), 0);
    chk("h_digit", int'(b8.digit), 1);
    step(P5, 0, 1, 0);
    chk("h_hold", int'(b8.digit), 1);

    // direction changes between samples
    step(P7, 1, 0, 0); chk("d_pos1", int'(b8.pos), 1);
    step(P9, 1, 1, 0); chk("d_pos2", int'(b8.pos), 2);
    step(P7, 1, 0, 0);
    step(P5, 1, 0, 0);
    step(P3, 1, 0, 0); chk("d_pos4", int'(b8.pos), 4);
    step(P5, 1, 1, 0); chk("d_pos0", int'(b8.pos), 0);
    step(P9, 1, 1, 1);
    chk("d_err", int'(b8.err), 1);
    chk("d_clr", int'(b8.err_count), 0);
    step(PB, 0, 1, 0);
    step(PB, 0, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
